// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the x^32+x^7+x^6+x^2+1 Fibonacci LFSR bit stream: self-syncs, locks, counts bit errors.
// Optional seed-load ports are enabled by defining LFSR_CHECKER_SEED_LOAD_EN.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT    = 64,
  parameter int LOSS_WINDOW   = 64,
  parameter int LOSS_ERRORS   = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_bit,
  input  logic                     in_valid,
  input  logic                     clear_count,
`ifdef LFSR_CHECKER_SEED_LOAD_EN
  input  logic [31:0]              seed,
  input  logic                     load_seed,
`endif
  output logic                     locked,
  output logic                     bit_error,
  output logic                     sync_loss,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic                     dbg_state
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRORS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERRORS - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state, state_n;
  logic [31:0]              history, history_n;
  logic [MW-1:0]            match_cnt, match_n;
  logic [WW-1:0]            window_cnt, window_n;
  logic [EW-1:0]            win_err, win_err_n;
  logic                     bit_error_n, sync_loss_n;
  logic [ERR_CNT_WIDTH-1:0] error_count_n;
  logic                     predicted, mismatch;

  assign predicted = history[31] ^ history[6] ^ history[5] ^ history[1];
  assign mismatch  = in_bit ^ predicted;
  assign locked    = (state == LOCKED);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      history     <= '0;
      match_cnt   <= '0;
      window_cnt  <= '0;
      win_err     <= '0;
      bit_error   <= 1'b0;
      sync_loss   <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_n;
      history     <= history_n;
      match_cnt   <= match_n;
      window_cnt  <= window_n;
      win_err     <= win_err_n;
      bit_error   <= bit_error_n;
      sync_loss   <= sync_loss_n;
      error_count <= error_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    history_n     = history;
    match_n       = match_cnt;
    window_n      = window_cnt;
    win_err_n     = win_err;
    bit_error_n   = 1'b0;
    sync_loss_n   = 1'b0;
    error_count_n = error_count;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          // An all-zero history would predict zero forever, so a dead line must never count as a match.
          history_n = {history[30:0], in_bit};
          if (mismatch || (history == 32'd0)) begin
            match_n = '0;
          end else if (match_cnt == MATCH_LAST) begin
            state_n  = LOCKED;
            match_n  = '0;
            window_n = '0;
            win_err_n = '0;
          end else begin
            match_n = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          // Regenerate locally from predictions so a line error cannot propagate into later predictions.
          history_n = {history[30:0], predicted};
          if (mismatch) begin
            bit_error_n = 1'b1;
            if (error_count != {ERR_CNT_WIDTH{1'b1}}) error_count_n = error_count + 1'b1;
          end
          if (mismatch && (win_err == ERR_LAST)) begin
            state_n     = SEARCH;
            match_n     = '0;
            sync_loss_n = 1'b1;
          end else if (window_cnt == WIN_LAST) begin
            window_n  = '0;
            win_err_n = '0;
          end else begin
            window_n = window_cnt + 1'b1;
            if (mismatch) win_err_n = win_err + 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    if (clear_count) error_count_n = '0;
`ifdef LFSR_CHECKER_SEED_LOAD_EN
    if (load_seed) begin
      state_n       = LOCKED;
      history_n     = seed;
      match_n       = '0;
      window_n      = '0;
      win_err_n     = '0;
      bit_error_n   = 1'b0;
      sync_loss_n   = 1'b0;
      error_count_n = clear_count ? '0 : error_count;
    end
`endif
  end
endmodule
